// File: rtl/tone_voice_env.sv
// Single-voice square-wave tone generator with ADSR-style envelope
// and 1-bit PWM audio output running at clk rate.
module tone_voice_env #(
  parameter int SYNTH_DIV   = 1024,
  parameter int ENV_DIV     = 64,
  parameter int SUSTAIN_LVL = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] hp,
  input  logic       active,
  output logic       audio,
  output logic [3:0] env_level,
  output logic       busy
);

  localparam int PW = $clog2(SYNTH_DIV);
  localparam int EW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SYNTH_DIV - 1);
  localparam logic [EW-1:0] ENV_MAX = EW'(ENV_DIV - 1);
  localparam logic [3:0] SUS = 4'(SUSTAIN_LVL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_t;

  state_t        state, state_n;
  logic [3:0]    level, level_n;
  logic [PW-1:0] pre_ctr;
  logic [EW-1:0] env_ctr;
  logic [6:0]    ph_ctr;
  logic [3:0]    pwm_ctr;
  logic          osc;
  logic          active_q;
  logic          synth_tick;
  logic          env_tick;
  logic          note_on;
  logic          note_off;
  logic [3:0]    lvl_up;
  logic [3:0]    lvl_dn;

  assign synth_tick = (pre_ctr == PRE_MAX);
  assign env_tick   = synth_tick & (env_ctr == ENV_MAX);
  assign note_on    = active & ~active_q;
  assign note_off   = ~active & active_q;
  assign lvl_up     = (level > 4'd13) ? 4'd15 : level + 4'd2;
  assign lvl_dn     = (level == 4'd0) ? 4'd0 : level - 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_ctr  <= '0;
      pwm_ctr  <= '0;
      active_q <= 1'b0;
    end else begin
      pre_ctr  <= pre_ctr + PW'(1);
      pwm_ctr  <= pwm_ctr + 4'd1;
      active_q <= active;
    end
  end

  // hp is used live; >= lets a shrinking period wrap at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_ctr <= '0;
      osc    <= 1'b0;
    end else if (synth_tick) begin
      if (hp == 7'd0) begin
        ph_ctr <= '0;
        osc    <= 1'b0;
      end else if (ph_ctr >= hp - 7'd1) begin
        ph_ctr <= '0;
        osc    <= ~osc;
      end else begin
        ph_ctr <= ph_ctr + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_ctr <= '0;
    end else if (note_on | note_off) begin
      env_ctr <= '0;
    end else if (synth_tick) begin
      env_ctr <= (env_ctr == ENV_MAX) ? '0 : env_ctr + EW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      level <= 4'd0;
    end else begin
      state <= state_n;
      level <= level_n;
    end
  end

  // gate edges win over a coincident envelope step
  always_comb begin
    state_n = state;
    level_n = level;
    if (note_on) begin
      state_n = S_ATTACK;
    end else if (note_off && state != S_IDLE) begin
      state_n = S_RELEASE;
    end else if (env_tick) begin
      unique case (state)
        S_ATTACK: begin
          level_n = lvl_up;
          if (lvl_up == 4'd15) state_n = S_DECAY;
        end
        S_DECAY: begin
          if (level > SUS) level_n = lvl_dn;
          if (lvl_dn <= SUS) state_n = S_SUSTAIN;
        end
        S_RELEASE: begin
          level_n = lvl_dn;
          if (lvl_dn == 4'd0) state_n = S_IDLE;
        end
        default: begin
          level_n = level;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio <= 1'b0;
    end else begin
      audio <= osc & (pwm_ctr < level);
    end
  end

  assign env_level = level;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_tone_voice_env.sv
// Bench for tone_voice_env: cycle model built from integer counters
// plus directed envelope/duty/reset checks and a randomized phase.
module tb_tone_voice_env;

  localparam int SD = 4;
  localparam int ED = 2;
  localparam int SL = 10;
  localparam int MI = 0;
  localparam int MA = 1;
  localparam int MD = 2;
  localparam int MS = 3;
  localparam int MR = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       active = 1'b0;
  logic [6:0] hp = 7'd3;
  logic       audio;
  logic [3:0] env_level;
  logic       busy;

  int n_pass = 0;
  int n_total = 0;
  int q_v[$];
  int q_t[$];

  int m_k, m_aq, m_tk, m_ph, m_osc, m_mode, m_lvl, m_audio;
  int n_k, n_aq, n_tk, n_ph, n_osc, n_mode, n_lvl, n_audio;
  bit tick, on, off, etick;

  tone_voice_env #(
    .SYNTH_DIV(SD),
    .ENV_DIV(ED),
    .SUSTAIN_LVL(SL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hp(hp),
    .active(active),
    .audio(audio),
    .env_level(env_level),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // model: m_k counts edges since reset, m_tk synth ticks since gate edge
  always_comb begin
    tick  = (m_k % SD) == SD - 1;
    on    = active && (m_aq == 0);
    off   = !active && (m_aq == 1);
    etick = tick && ((m_tk % ED) == ED - 1);
    n_k   = m_k + 1;
    n_aq  = active ? 1 : 0;
    n_tk  = (on || off) ? 0 : (tick ? m_tk + 1 : m_tk);
    n_ph  = m_ph;
    n_osc = m_osc;
    if (tick) begin
      if (hp == 7'd0) begin
        n_ph  = 0;
        n_osc = 0;
      end else if (m_ph >= int'(hp) - 1) begin
        n_ph  = 0;
        n_osc = 1 - m_osc;
      end else begin
        n_ph = m_ph + 1;
      end
    end
    n_mode = m_mode;
    n_lvl  = m_lvl;
    if (on) begin
      n_mode = MA;
    end else if (off && m_mode != MI) begin
      n_mode = MR;
    end else if (etick) begin
      case (m_mode)
        MA: begin
          n_lvl = (m_lvl + 2 > 15) ? 15 : m_lvl + 2;
          if (n_lvl == 15) n_mode = MD;
        end
        MD: begin
          n_lvl = m_lvl - 1;
          if (n_lvl <= SL) n_mode = MS;
        end
        MR: begin
          n_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
          if (n_lvl == 0) n_mode = MI;
        end
        default: n_lvl = m_lvl;
      endcase
    end
    n_audio = (m_osc == 1 && (m_k % 16) < m_lvl) ? 1 : 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k <= 0; m_aq <= 0; m_tk <= 0; m_ph <= 0;
      m_osc <= 0; m_mode <= MI; m_lvl <= 0; m_audio <= 0;
    end else begin
      m_k <= n_k; m_aq <= n_aq; m_tk <= n_tk; m_ph <= n_ph;
      m_osc <= n_osc; m_mode <= n_mode; m_lvl <= n_lvl;
      m_audio <= n_audio;
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic compare_loop();
    logic [5:0] e;
    logic [5:0] g;
    forever begin
      @(negedge clk);
      e = {m_audio[0], m_lvl[3:0], (m_mode != MI)};
      g = {audio, env_level, busy};
      n_total++;
      if (g === e) n_pass++;
      else $display("FAIL model t=%0t got a/l/b=%b/%0d/%b expected %b/%0d/%b",
                    $time, g[5], g[4:1], g[0], e[5], e[4:1], e[0]);
    end
  endtask

  task automatic record(input int n);
    q_v = {};
    q_t = {};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (q_v.size() == 0 || int'(env_level) != q_v[$]) begin
        q_v.push_back(int'(env_level));
        q_t.push_back(i);
      end
    end
  endtask

  task automatic wait_lvl(input int tgt, input int budget, input string nm);
    q_v = {};
    q_v.push_back(int'(env_level));
    for (int i = 0; i < budget && int'(env_level) != tgt; i++) begin
      @(negedge clk);
      if (int'(env_level) != q_v[$]) q_v.push_back(int'(env_level));
    end
    check(nm, int'(env_level), tgt);
  endtask

  task automatic cmp_seq(input string nm, input int e[$]);
    check({nm, "_len"}, q_v.size(), e.size());
    for (int i = 0; i < e.size() && i < q_v.size(); i++)
      check($sformatf("%s_%0d", nm, i), q_v[i], e[i]);
  endtask

  task automatic spacing(input string nm);
    int bad = 0;
    for (int i = 2; i < q_t.size(); i++)
      if (q_t[i] - q_t[i-1] != 8) bad++;
    check(nm, bad, 0);
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (audio) c++;
    end
  endtask

  task automatic duty(output int c);
    int lows = 0;
    bit found = 0;
    c = -1;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (audio) begin
        if (lows >= 16) found = 1;
        lows = 0;
      end else begin
        lows++;
      end
    end
    if (found) begin
      c = 1;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (audio) c++;
      end
    end
  endtask

  initial begin
    int e[$];
    int c;
    #1 rst_n = 1'b0;
    #20;
    check("rst_audio", int'(audio), 0);
    check("rst_level", int'(env_level), 0);
    check("rst_busy", int'(busy), 0);
    fork
      compare_loop();
    join_none
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    active = 1'b1;
    record(140);
    e = '{0, 2, 4, 6, 8, 10, 12, 14, 15, 14, 13, 12, 11, 10};
    cmp_seq("attack", e);
    spacing("attack_spacing");
    check("first_step_lat", (q_t.size() > 1 && q_t[1] >= 5 && q_t[1] <= 8) ? 1 : 0, 1);
    check("sustain_busy", int'(busy), 1);

    hp = 7'd127;
    duty(c);
    check("duty_lvl10", c, 10);
    hp = 7'd0;
    repeat (10) @(negedge clk);
    count_high(40, c);
    check("hp0_silent", c, 0);
    hp = 7'd3;
    repeat (30) @(negedge clk);

    active = 1'b0;
    record(120);
    e = {};
    for (int i = 10; i >= 0; i--) e.push_back(i);
    cmp_seq("release", e);
    spacing("release_spacing");
    check("release_idle", int'(busy), 0);
    count_high(20, c);
    check("idle_silent", c, 0);

    active = 1'b1;
    repeat (150) @(negedge clk);
    check("sus_again", int'(env_level), SL);
    active = 1'b0;
    wait_lvl(5, 100, "rel_to5");
    active = 1'b1;
    wait_lvl(9, 100, "att_to9");
    e = '{5, 7, 9};
    cmp_seq("retrig", e);
    active = 1'b0;
    record(100);
    e = {};
    for (int i = 9; i >= 0; i--) e.push_back(i);
    cmp_seq("rel9", e);
    check("rel9_idle", int'(busy), 0);

    active = 1'b1;
    repeat (20) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_audio", int'(audio), 0);
    check("async_level", int'(env_level), 0);
    check("async_busy", int'(busy), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reattack_busy", int'(busy), 1);
    check("reattack_level", int'(env_level), 0);

    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      hp = 7'($urandom_range(0, 5));
      active = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end
    active = 1'b0;
    repeat (120) @(negedge clk);
    check("final_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tone_voice_env.md
# tone_voice_env

Single-voice tone generator with amplitude envelope that sits directly downstream of the sequencer in the audio path. It consumes the sequencer's half-period code `hp` and gate `active`, produces a square-wave oscillator, shapes it with an attack/decay/sustain/release envelope, and emits a 1-bit PWM audio stream at `clk` rate.

## Interface

- `SYNTH_DIV`, default 1024: clk cycles per synth tick; power of two, ≥ 2.
- `ENV_DIV`, default 64: synth ticks per envelope step; ≥ 1.
- `SUSTAIN_LVL`, default 10: sustain level, 1..14.
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `hp`  input  7  oscillator half-period in synth ticks; 0 = silence.
- `active`  input  1  note gate from the sequencer; level-sensitive.
- `audio`  output  1  registered PWM audio.
- `env_level`  output  4  current envelope amplitude, 0..15.
- `busy`  output  1  high whenever envelope state ≠ IDLE.

## Operation

- Prescaler: `pre_ctr` counts 0..SYNTH_DIV-1, free-running. `synth_tick` is a one-clk pulse when `pre_ctr == SYNTH_DIV-1`.
- Oscillator: 7-bit `ph_ctr`, 1-bit `osc`, updated only on `synth_tick`.
  - `hp == 0`: `ph_ctr` ← 0, `osc` ← 0.
  - Else if `ph_ctr >= hp-1`: `ph_ctr` ← 0, `osc` toggles. Uses `>=`, so a shrinking `hp` wraps on the next tick and never overruns.
  - Else `ph_ctr` increments.
  - `hp` is sampled live, with no latching.
- Gate edges: `active_q` registers `active` every clk.
  - `note_on = active & ~active_q`.
  - `note_off = ~active & active_q`.
- Envelope divider: `env_ctr` counts synth ticks 0..ENV_DIV-1. `env_tick` fires on the `synth_tick` where `env_ctr == ENV_DIV-1`. `env_ctr` clears to 0 on `note_on` or `note_off`.
- Envelope FSM, 4-bit saturating `level`. States and transitions:
  - IDLE: `level` = 0. `note_on` → ATTACK.
  - ATTACK: each `env_tick`, `level` ← min(level+2, 15). When it reaches 15 → DECAY. `note_off` → RELEASE.
  - DECAY: each `env_tick`, `level` −1. When it reaches SUSTAIN_LVL → SUSTAIN. `note_off` → RELEASE.
  - SUSTAIN: hold `level`. `note_off` → RELEASE.
  - RELEASE: each `env_tick`, `level` −1. When it reaches 0 → IDLE. `note_on` → ATTACK.
  - `note_on` from any state → ATTACK (retrigger). `level` is kept, not reset, on retrigger.
  - Edge events take priority over an `env_tick` in the same clk; the step is dropped.
  - A `note_off` arriving in IDLE is ignored.
- PWM: 4-bit `pwm_ctr` increments every clk, wraps 15 → 0.
  - `audio` ← `osc & (pwm_ctr < level)`, registered.
  - `level` 15 gives 15/16 duty while `osc` is high; `level` 0 gives a constant 0.
- `env_level` = `level` register. `busy` = (state ≠ IDLE).

## Timing

- Reset, asynchronous: `audio` = 0, `env_level` = 0, `busy` = 0, state IDLE. All counters, `osc` and `active_q` are 0.
- Gate latency: `active` rising before edge N gives ATTACK and `busy` = 1 after edge N. `note_off` behaves identically.
- First envelope step after any gate edge: exactly ENV_DIV synth ticks later, so the divider's phase relative to `pre_ctr` is arbitrary.
- `audio` lags `osc`/`level` by one clk.
- Oscillator period is 2·hp synth ticks, i.e. 2·hp·SYNTH_DIV clk.
- A mid-note `rst_n` assertion aborts immediately to reset values. After release, a held-high `active` counts as a fresh `note_on`, because `active_q` = 0.

## Test plan

Bench parameters: SYNTH_DIV=4, ENV_DIV=2, SUSTAIN_LVL=10.

1. Reset: pulse `rst_n` low mid-ATTACK with `active` high → `audio`/`env_level`/`busy` = 0 asynchronously. After release, ATTACK re-enters on the next clk.
2. Oscillator: `hp`=3, `active`=1 → `osc` toggles every 12 clk (period 24 clk). Switching to `hp`=1 while `ph_ctr`=2 → toggle on the next `synth_tick`. `hp`=0 → `audio` stays 0.
3. Attack/decay: `active` rises → `env_level` steps 2,4,…,14,15, one step every 8 clk (15 reached after 8 steps = 64 clk). It then steps 14,13,12,11,10 and holds at 10.
4. Release: drop `active` in SUSTAIN → `env_level` falls 9..0 in 10 steps (80 clk). `busy` → 0 at level 0 and `audio` stays 0.
5. Retrigger: raise `active` during RELEASE at `level`=5 → ATTACK with 7,9,…,15. Dropping `active` in ATTACK at level 9 → RELEASE from 9.
6. PWM duty: `level`=15 with `osc` high → `audio` high 15 of every 16 clk. At `level`=4 → 4 of 16 clk.
